// File: rtl/ps2_pkg.sv
// PS/2 host-side shared definitions: frame layout, command/response
// bytes and the host transmit FSM states.
package ps2_pkg;

   localparam int PS2_FRAME_BITS = 11;

   // zero-based falling-edge index within the host-driven part of the frame
   localparam logic [3:0] PS2_PARITY_IDX = 4'd8;
   localparam logic [3:0] PS2_STOP_IDX   = 4'(PS2_FRAME_BITS - 2);

   localparam logic [7:0] PS2_SET_LEDS = 8'hED;
   localparam logic [7:0] PS2_ECHO     = 8'hEE;
   localparam logic [7:0] PS2_RESET    = 8'hFF;
   localparam logic [7:0] PS2_ACK      = 8'hFA;
   localparam logic [7:0] PS2_RESEND   = 8'hFE;

   typedef enum logic [2:0] {
      IDLE,
      INHIBIT,
      START,
      XMIT,
      ACK,
      WAIT_IDLE
   } ps2_tx_state_t;

   function automatic logic ps2_odd_parity(input logic [7:0] b);
      return ~^b;
   endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Three-flop synchronizer for one raw PS/2 line with falling-edge detect.
// Flops reset high so a released (idle) line never shows a false edge.
module ps2_line_sync (
   input  logic clk,
   input  logic clrn,
   input  logic i_line,
   output logic o_level,
   output logic o_fe
);

   logic [2:0] r_sync;

   always_ff @(posedge clk) begin
      if (!clrn) begin
         r_sync <= 3'b111;
      end else begin
         r_sync <= {r_sync[1:0], i_line};
      end
   end

   assign o_level = r_sync[1];
   assign o_fe    = r_sync[2] & ~r_sync[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: clock inhibit, request-to-send, device
// clocked data/parity/stop, then ACK check. busy gates the keyboard receiver.
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int CLK_INHIBIT_CYCLES = 10000,
   parameter int TIMEOUT_CYCLES     = 1000000
) (
   input  logic       clk,
   input  logic       clrn,
   input  logic       send_valid,
   input  logic [7:0] send_data,
   output logic       busy,
   output logic       done,
   output logic       err,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_drive_low,
   output logic       ps2_data_drive_low
);

   localparam int INH_W = $clog2(CLK_INHIBIT_CYCLES + 1);
   localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [INH_W-1:0] INH_LAST = INH_W'(CLK_INHIBIT_CYCLES - 1);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

   ps2_tx_state_t    r_state;
   logic [7:0]       r_data;
   logic             r_parity;
   logic [INH_W-1:0] r_inh_cnt;
   logic [TO_W-1:0]  r_to_cnt;
   logic [3:0]       r_bit_idx;
   logic             r_busy;
   logic             r_done;
   logic             r_err;
   logic             r_err_next;
   logic             r_clk_low;
   logic             r_data_low;

   logic w_clk_lvl;
   logic w_clk_fe;
   logic w_dat_lvl;
   logic w_unused_dat_fe;
   logic w_timeout;

   ps2_line_sync u_clk_sync (
      .clk     (clk),
      .clrn    (clrn),
      .i_line  (ps2_clk_in),
      .o_level (w_clk_lvl),
      .o_fe    (w_clk_fe)
   );

   ps2_line_sync u_dat_sync (
      .clk     (clk),
      .clrn    (clrn),
      .i_line  (ps2_data_in),
      .o_level (w_dat_lvl),
      .o_fe    (w_unused_dat_fe)
   );

   assign w_timeout = (r_to_cnt == TO_LAST);

   always_ff @(posedge clk) begin
      if (!clrn) begin
         r_state    <= IDLE;
         r_data     <= '0;
         r_parity   <= 1'b0;
         r_inh_cnt  <= '0;
         r_to_cnt   <= '0;
         r_bit_idx  <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
         r_err_next <= 1'b0;
         r_clk_low  <= 1'b0;
         r_data_low <= 1'b0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            IDLE: begin
               if (send_valid) begin
                  r_data    <= send_data;
                  r_parity  <= ps2_odd_parity(send_data);
                  r_inh_cnt <= '0;
                  r_busy    <= 1'b1;
                  r_clk_low <= 1'b1;
                  r_state   <= INHIBIT;
               end
            end
            INHIBIT: begin
               if (r_inh_cnt == INH_LAST) begin
                  r_data_low <= 1'b1;
                  r_state    <= START;
               end else begin
                  r_inh_cnt <= r_inh_cnt + INH_W'(1);
               end
            end
            START: begin
               r_clk_low <= 1'b0;
               r_to_cnt  <= '0;
               r_bit_idx <= '0;
               r_state   <= XMIT;
            end
            XMIT: begin
               // a timeout outranks an edge seen in the same cycle
               if (w_timeout) begin
                  r_clk_low  <= 1'b0;
                  r_data_low <= 1'b0;
                  r_done     <= 1'b1;
                  r_err      <= 1'b1;
                  r_busy     <= 1'b0;
                  r_state    <= IDLE;
               end else begin
                  r_to_cnt <= r_to_cnt + TO_W'(1);
                  if (w_clk_fe) begin
                     r_bit_idx <= r_bit_idx + 4'd1;
                     unique case (1'b1)
                        (r_bit_idx < PS2_PARITY_IDX):
                           r_data_low <= ~r_data[r_bit_idx[2:0]];
                        (r_bit_idx == PS2_PARITY_IDX):
                           r_data_low <= ~r_parity;
                        default: begin
                           r_data_low <= 1'b0;
                           r_state    <= ACK;
                        end
                     endcase
                  end
               end
            end
            ACK: begin
               if (w_timeout) begin
                  r_clk_low  <= 1'b0;
                  r_data_low <= 1'b0;
                  r_done     <= 1'b1;
                  r_err      <= 1'b1;
                  r_busy     <= 1'b0;
                  r_state    <= IDLE;
               end else begin
                  r_to_cnt <= r_to_cnt + TO_W'(1);
                  if (w_clk_fe) begin
                     r_err_next <= w_dat_lvl;
                     r_state    <= WAIT_IDLE;
                  end
               end
            end
            WAIT_IDLE: begin
               if (w_clk_lvl && w_dat_lvl) begin
                  r_done  <= 1'b1;
                  r_err   <= r_err_next;
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign busy               = r_busy;
   assign done               = r_done;
   assign err                = r_err;
   assign ps2_clk_drive_low  = r_clk_low;
   assign ps2_data_drive_low = r_data_low;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain lines with a PS/2 device model and a
// cycle-level reference of the host request/timeout/done rules.
module tb_ps2_host_tx;
   import ps2_pkg::*;

   localparam int N   = 20;
   localparam int T   = 100;
   localparam int BIG = 32'h3fff_ffff;

   logic       clk = 1'b0;
   logic       clrn;
   logic       send_valid;
   logic [7:0] send_data;
   logic       busy;
   logic       done;
   logic       err;
   logic       ps2_clk_in;
   logic       ps2_data_in;
   logic       ps2_clk_drive_low;
   logic       ps2_data_drive_low;
   logic       dev_clk_low;
   logic       dev_data_low;

   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc   = 0;
   int   t_acc;
   int   t_lo;
   int   t_hi;
   int   m_rst_c;
   bit   m_on;
   logic m_err;
   logic m_exp_err;
   int   run = 0;
   int   last_run = 0;
   int   last_fall = 0;
   int   dat_rise_c = 0;
   int   last_done_c = 0;
   logic prev_dat = 1'b0;

   ps2_host_tx #(
      .CLK_INHIBIT_CYCLES (N),
      .TIMEOUT_CYCLES     (T)
   ) dut (
      .clk                (clk),
      .clrn               (clrn),
      .send_valid         (send_valid),
      .send_data          (send_data),
      .busy               (busy),
      .done               (done),
      .err                (err),
      .ps2_clk_in         (ps2_clk_in),
      .ps2_data_in        (ps2_data_in),
      .ps2_clk_drive_low  (ps2_clk_drive_low),
      .ps2_data_drive_low (ps2_data_drive_low)
   );

   // open-drain wiring with pull-ups
   assign ps2_clk_in  = ~(ps2_clk_drive_low | dev_clk_low);
   assign ps2_data_in = ~(ps2_data_drive_low | dev_data_low);

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1000000;
      $display("FAIL watchdog: sim time exhausted, want $finish earlier");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @cyc %0d: got %0h want %0h", nm, cyc, act, exp);
      end
   endtask

   function automatic logic [10:0] frame_of(input logic [7:0] b);
      return {1'b1, ~^b, b, 1'b0};
   endfunction

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   // reference: request at t_acc, N+1 cycles clock low, start bit at N,
   // done inside [t_lo, t_hi], err held between done pulses
   always @(negedge clk) begin
      int n;
      if (m_on && cyc >= m_rst_c) begin
         m_on  = 1'b0;
         m_err = 1'b0;
      end
      if (ps2_clk_drive_low) begin
         run = run + 1;
      end else if (run > 0) begin
         last_run  = run;
         last_fall = cyc;
         run       = 0;
      end
      if (ps2_data_drive_low && !prev_dat && ps2_clk_drive_low)
         dat_rise_c = cyc;
      prev_dat = ps2_data_drive_low;
      if (done) last_done_c = cyc;
      if (!m_on) begin
         chk("idle_busy", busy, 0);
         chk("idle_done", done, 0);
         chk("idle_clk_low", ps2_clk_drive_low, 0);
         chk("idle_data_low", ps2_data_drive_low, 0);
         chk("idle_err", err, m_err);
      end else begin
         n = cyc - t_acc;
         chk("clk_low", ps2_clk_drive_low, n <= N);
         if (n <= N + 1) chk("data_low", ps2_data_drive_low, n >= N);
         if (cyc < t_lo) begin
            chk("busy", busy, 1);
            chk("early_done", done, 0);
            chk("err_hold", err, m_err);
         end else if (done) begin
            chk("done_err", err, m_exp_err);
            chk("done_busy", busy, 0);
            chk("done_data_low", ps2_data_drive_low, 0);
            m_err = m_exp_err;
            m_on  = 1'b0;
         end else if (cyc >= t_hi) begin
            chk("done_due", done, 1);
            m_on = 1'b0;
         end else begin
            chk("busy_win", busy, 1);
            chk("err_win", err, m_err);
         end
      end
   end

   // device: wait for request-to-send, clock n_fe edges, optional ACK
   task automatic device_run(input int n_fe, input bit ack,
                             output logic [10:0] fr);
      bit ok;
      ok = 1'b0;
      fr = '0;
      for (int i = 0; i < N + 20 && !ok; i++) begin
         tick();
         ok = ps2_clk_in && !ps2_data_in;
      end
      chk("rts_seen", ok, 1);
      if (ok) begin
         repeat (2) tick();
         fr[0] = ps2_data_in;
         for (int i = 1; i <= n_fe; i++) begin
            dev_clk_low = 1'b1;
            repeat (4) tick();
            dev_clk_low = 1'b0;
            if (i <= 10) fr[i] = ps2_data_in;
            if (i < 11) begin
               repeat (2) tick();
               if (i == 10 && ack) dev_data_low = 1'b1;
               repeat (2) tick();
            end
         end
         if (n_fe == 11) begin
            tick();
            dev_data_low = 1'b0;
            t_lo = cyc + 1;
            t_hi = cyc + 6;
         end
      end
   endtask

   // mode: 0 ack, 1 no ack, 2 silent device, 3 valid held, 4 reset at fe 5
   task automatic send(input logic [7:0] b, input int mode,
                       input logic [10:0] lit, input logic lit_err);
      logic [10:0] fr;
      tick();
      send_data  = b;
      send_valid = 1'b1;
      t_acc      = cyc + 1;
      t_lo       = BIG;
      t_hi       = BIG;
      m_exp_err  = (mode == 1 || mode == 2);
      if (mode == 2) begin
         t_lo = t_acc + N + 1 + T;
         t_hi = t_lo;
      end
      m_on = 1'b1;
      tick();
      send_data = ~b;
      if (mode != 3) send_valid = 1'b0;
      if (mode == 2) begin
         fr = '0;
      end else begin
         device_run(mode == 4 ? 5 : 11, mode != 1, fr);
      end
      if (mode == 3) send_valid = 1'b0;
      if (mode == 4) begin
         tick();
         clrn    = 1'b0;
         m_rst_c = cyc + 1;
         repeat (2) tick();
         clrn    = 1'b1;
         tick();
         m_rst_c = BIG;
      end else begin
         for (int i = 0; i < 400 && m_on; i++) tick();
         if (m_on) begin
            chk("txn_end", m_on, 0);
            m_on = 1'b0;
         end
         if (mode != 2) begin
            chk("frame", fr, frame_of(b));
            if (lit != 0) chk("frame_lit", fr, lit);
         end
      end
      chk("err_after", err, lit_err);
   endtask

   initial begin
      clrn         = 1'b0;
      send_valid   = 1'b0;
      send_data    = 8'h00;
      dev_clk_low  = 1'b0;
      dev_data_low = 1'b0;
      m_on         = 1'b0;
      m_err        = 1'b0;
      m_exp_err    = 1'b0;
      m_rst_c      = BIG;
      t_acc        = 0;
      t_lo         = BIG;
      t_hi         = BIG;
      repeat (3) tick();
      clrn = 1'b1;
      repeat (2) tick();

      send(PS2_SET_LEDS, 0, 11'h7DA, 1'b0);
      chk("inhibit_len", last_run, 21);
      chk("start_lead", last_fall - dat_rise_c, 1);
      send(8'h07, 0, 11'h40E, 1'b0);
      send(8'h00, 0, 11'h600, 1'b0);
      send(PS2_RESET, 1, 11'h7FE, 1'b1);
      send(PS2_ECHO, 0, 11'h0, 1'b0);
      send(PS2_ACK, 2, 11'h0, 1'b1);
      chk("timeout_lat", last_done_c - last_fall, 100);
      send(PS2_RESEND, 3, 11'h0, 1'b0);
      repeat (10) tick();
      send(PS2_SET_LEDS, 4, 11'h0, 1'b0);
      repeat (5) tick();
      send(8'h5A, 0, 11'h0, 1'b0);
      repeat (5) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
